// File: rtl/mem_port_arbiter_if.sv
// Signal bundle of the shared memory port: fetch side, data side and the memory itself.
// slave is the arbiter's view, master is the requester/memory environment's view.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;

   logic        dm_req;
   logic        dm_we;
   logic [63:0] dm_addr;
   logic [63:0] dm_wdata;
   logic        dm_ack;
   logic [63:0] dm_rdata;
   logic        dm_err;

   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_wr;
   logic [63:0] mem_rdata;

   logic        busy;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata, dm_err, mem_addr, mem_wdata, mem_wr, busy
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata, dm_err, mem_addr, mem_wdata, mem_wr, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and load/store with
// fair alternation, a fixed memory latency and range checking of data addresses.
module mem_port_arbiter #(
   parameter int          MEM_LAT    = 1,
   parameter logic [63:0] DMEM_BYTES = 64'd2048
) (
   input  logic              Clk,
   input  logic              Reset,
   mem_port_arbiter_if.slave bus
);
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           state_reg, state_next;
   logic             grant_dm_reg, grant_dm_next;
   logic             last_dm_reg, last_dm_next;
   logic [63:2]      addr_reg, addr_next;
   logic             we_reg, we_next;
   logic [63:0]      wdata_reg, wdata_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             first_reg, first_next;
   logic             err_reg, err_next;
   logic [63:0]      word_reg, word_next;

   logic pick_dm;
   logic dm_range_err;
   logic if_ack;
   logic dm_ack;
   logic unused_addr_bits;

   // Byte-offset bits below the 32-bit half select carry no meaning here.
   assign unused_addr_bits = ^{bus.if_addr[1:0], bus.dm_addr[1:0]};

   assign pick_dm      = bus.dm_req && (!bus.if_req || !last_dm_reg);
   assign dm_range_err = (bus.dm_addr >= DMEM_BYTES);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_reg    <= IDLE;
         grant_dm_reg <= 1'b0;
         last_dm_reg  <= 1'b1;
         addr_reg     <= '0;
         we_reg       <= 1'b0;
         wdata_reg    <= '0;
         cnt_reg      <= '0;
         first_reg    <= 1'b0;
         err_reg      <= 1'b0;
         word_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         grant_dm_reg <= grant_dm_next;
         last_dm_reg  <= last_dm_next;
         addr_reg     <= addr_next;
         we_reg       <= we_next;
         wdata_reg    <= wdata_next;
         cnt_reg      <= cnt_next;
         first_reg    <= first_next;
         err_reg      <= err_next;
         word_reg     <= word_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      grant_dm_next = grant_dm_reg;
      last_dm_next  = last_dm_reg;
      addr_next     = addr_reg;
      we_next       = we_reg;
      wdata_next    = wdata_reg;
      cnt_next      = cnt_reg;
      first_next    = first_reg;
      err_next      = err_reg;
      word_next     = word_reg;

      case (state_reg)
         IDLE: begin
            if (bus.if_req || bus.dm_req) begin
               grant_dm_next = pick_dm;
               addr_next     = pick_dm ? bus.dm_addr[63:2] : bus.if_addr[63:2];
               we_next       = pick_dm && bus.dm_we;
               wdata_next    = pick_dm ? bus.dm_wdata : '0;
               err_next      = pick_dm && dm_range_err;
               cnt_next      = CNT_LOAD;
               first_next    = 1'b1;
               word_next     = '0;
               // Out-of-range data accesses never touch the memory.
               state_next    = (pick_dm && dm_range_err) ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            first_next = 1'b0;
            if (cnt_reg == '0) begin
               word_next  = bus.mem_rdata;
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         RESP: begin
            last_dm_next = grant_dm_reg;
            state_next   = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign if_ack = (state_reg == RESP) && !grant_dm_reg;
   assign dm_ack = (state_reg == RESP) && grant_dm_reg;

   assign bus.busy      = (state_reg != IDLE);
   assign bus.mem_addr  = (state_reg == ACCESS) ? {addr_reg[63:3], 3'b000} : '0;
   assign bus.mem_wdata = (state_reg == ACCESS) ? wdata_reg : '0;
   // Strobe only in the first ACCESS cycle so a write commits exactly once.
   assign bus.mem_wr    = (state_reg == ACCESS) && first_reg && we_reg;

   assign bus.if_ack    = if_ack;
   assign bus.if_rdata  = if_ack ? (addr_reg[2] ? word_reg[63:32] : word_reg[31:0]) : '0;
   assign bus.dm_ack    = dm_ack;
   assign bus.dm_err    = dm_ack && err_reg;
   assign bus.dm_rdata  = (dm_ack && !we_reg && !err_reg) ? word_reg : '0;
endmodule
